fetch_stage_pipelined: RTL and testbench

//  Parametrised instruction-fetch stage: owns the PC and issues reads to a 1-cycle-latency instruction memory.

---
 rtl/fetch_stage_pipelined_pkg.sv | 25 ++
 rtl/fetch_stage_pipelined_skid_buf.sv | 38 +++
 rtl/fetch_stage_pipelined.sv | 137 +++++++++++++
 tb/tb_fetch_stage_pipelined.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pipelined_pkg.sv
// Shared types and helpers for the instruction-fetch stage.
// fetch_if_t is the IF/ID pipeline register layout at the default widths.
// Optional build macro: FETCH_PERF_EN (adds saturating performance counters).
package fetch_stage_pipelined_pkg;

   localparam int FETCH_PC_W    = 16;
   localparam int FETCH_INSTR_W = 16;

   typedef struct packed {
      logic                     valid;
      logic [FETCH_PC_W-1:0]    pc;
      logic [FETCH_PC_W-1:0]    npc;
      logic [FETCH_INSTR_W-1:0] instr;
   } fetch_if_t;

   localparam int IF_ID_WIDTH = $bits(fetch_if_t);

   // Saturating accumulate for the performance counters; sticks at all-ones.
   function automatic logic [31:0] perf_sat_add(input logic [31:0] acc, input logic [1:0] inc);
      logic [32:0] sum;
      sum = {1'b0, acc} + {31'b0, inc};
      return sum[32] ? '1 : sum[31:0];
   endfunction

endpackage

// File: rtl/fetch_stage_pipelined_skid_buf.sv
// fetch_skid_buf: single-entry holding register for a fetch response that
// returns while decode is stalled. Priority: flush > load > drain.
module fetch_skid_buf #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_i,
   input  logic              drain_i,
   input  logic              flush_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o
);

   logic              valid_q;
   logic [DATA_W-1:0] data_q;

   // Entry state: capture on load, release on drain, drop on flush.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (flush_i) begin
         valid_q <= 1'b0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         data_q  <= data_i;
      end else if (drain_i) begin
         valid_q <= 1'b0;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/fetch_stage_pipelined.sv
// Instruction-fetch stage: owns the PC, issues reads to a 1-cycle-latency
// instruction memory and fills the IF/ID register {valid, pc, npc, instr}.
// Handles decode stall via a 1-entry skid buffer and redirect flush.
// Optional build macro: FETCH_PERF_EN adds o_perf_fetched / o_perf_flushed.
module fetch_stage_pipelined
   import fetch_stage_pipelined_pkg::*;
#(
   parameter int               PC_W     = FETCH_PC_W,
   parameter int               INSTR_W  = FETCH_INSTR_W,
   parameter int               PC_INC   = 2,
   parameter logic [PC_W-1:0]  RESET_PC = '0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_stall,
   input  logic               i_taken,
   input  logic [PC_W-1:0]    i_bt,
   output logic [PC_W-1:0]    o_pc_addr,
   output logic               o_pc_rd,
   input  logic [INSTR_W-1:0] i_pc_rddata,
   output logic               o_if_valid,
   output logic [PC_W-1:0]    o_if_pc,
   output logic [PC_W-1:0]    o_if_npc,
   output logic [INSTR_W-1:0] o_if_instr
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]        o_perf_fetched,
   output logic [31:0]        o_perf_flushed
`endif
);

   localparam logic [PC_W-1:0] INC        = PC_W'(PC_INC);
   localparam logic [PC_W-1:0] ALIGN_MASK = ~(INC - PC_W'(1));

   typedef struct packed {
      logic               valid;
      logic [PC_W-1:0]    pc;
      logic [PC_W-1:0]    npc;
      logic [INSTR_W-1:0] instr;
   } if_reg_t;

   logic [PC_W-1:0] pc_q, pc_d;
   logic            req_v_q, req_v_d;
   logic [PC_W-1:0] req_pc_q, req_pc_d;
   if_reg_t         if_q, if_d;

   logic               issue;
   logic               skid_v, skid_load, skid_drain;
   logic [PC_W-1:0]    skid_pc;
   logic [INSTR_W-1:0] skid_instr;

   assign issue   = !i_stall || i_taken;
   assign o_pc_rd = issue && !reset;

   assign skid_load  = !i_taken && i_stall && req_v_q;
   assign skid_drain = !i_taken && !i_stall && skid_v;

   fetch_skid_buf #(
      .DATA_W (PC_W + INSTR_W)
   ) u_skid (
      .clk     (clk),
      .reset   (reset),
      .load_i  (skid_load),
      .drain_i (skid_drain),
      .flush_i (i_taken),
      .data_i  ({req_pc_q, i_pc_rddata}),
      .valid_o (skid_v),
      .data_o  ({skid_pc, skid_instr})
   );

   // Next-state for PC, outstanding request and IF/ID: taken > stall > normal.
   always_comb begin
      // NOTE: every output gets a default first, so no path can infer a latch.
      pc_d     = pc_q;
      req_v_d  = 1'b0;
      req_pc_d = req_pc_q;
      if_d     = if_q;
      if (i_taken) begin
         pc_d       = i_bt & ALIGN_MASK;
         if_d.valid = 1'b0;
      end else if (!i_stall) begin
         pc_d     = pc_q + INC;
         req_v_d  = 1'b1;
         req_pc_d = pc_q;
         if (skid_v) begin
            if_d = '{valid: 1'b1, pc: skid_pc, npc: skid_pc + INC, instr: skid_instr};
         end else begin
            if_d = '{valid: req_v_q, pc: req_pc_q, npc: req_pc_q + INC, instr: i_pc_rddata};
         end
      end
   end

   // PC, request tracking and IF/ID register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q     <= RESET_PC;
         req_v_q  <= 1'b0;
         req_pc_q <= '0;
         if_q     <= '0;
      end else begin
         pc_q     <= pc_d;
         req_v_q  <= req_v_d;
         req_pc_q <= req_pc_d;
         if_q     <= if_d;
      end
   end

   assign o_pc_addr  = pc_q;
   assign o_if_valid = if_q.valid;
   assign o_if_pc    = if_q.pc;
   assign o_if_npc   = if_q.npc;
   assign o_if_instr = if_q.instr;

`ifdef FETCH_PERF_EN
   logic [31:0] fetched_q, flushed_q;
   logic [1:0]  killed;
   logic        load_live;

   assign killed    = {1'b0, req_v_q} + {1'b0, skid_v} + {1'b0, if_q.valid};
   assign load_live = !i_taken && !i_stall && if_d.valid;

   // Saturating counters of delivered and redirect-killed fetches.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetched_q <= '0;
         flushed_q <= '0;
      end else begin
         if (load_live) fetched_q <= perf_sat_add(fetched_q, 2'd1);
         if (i_taken)   flushed_q <= perf_sat_add(flushed_q, killed);
      end
   end

   assign o_perf_fetched = fetched_q;
   assign o_perf_flushed = flushed_q;
`endif

endmodule

// File: tb/tb_fetch_stage_pipelined.sv
// Directed bench for fetch_stage_pipelined: a per-cycle vector table covers
// streaming, stall/skid, redirect and redirect-under-stall; hand-written
// sequences cover PC wrap (second instance) and reset asserted mid-stall.
module tb_fetch_stage_pipelined;

   logic        clk = 1'b0;
   logic        reset, stall, taken;
   logic [15:0] bt;
   logic [15:0] pc_addr, rddata;
   logic        pc_rd;
   logic        if_valid;
   logic [15:0] if_pc, if_npc, if_instr;

   logic        rst_w;
   logic [15:0] w_addr, w_rddata;
   logic        w_rd;
   logic        w_valid;
   logic [15:0] w_pc, w_npc, w_instr;

`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched, perf_flushed, w_perf_fetched, w_perf_flushed;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fetch_stage_pipelined dut (
      .clk(clk), .reset(reset), .i_stall(stall), .i_taken(taken), .i_bt(bt),
      .o_pc_addr(pc_addr), .o_pc_rd(pc_rd), .i_pc_rddata(rddata),
      .o_if_valid(if_valid), .o_if_pc(if_pc), .o_if_npc(if_npc), .o_if_instr(if_instr)
`ifdef FETCH_PERF_EN
      , .o_perf_fetched(perf_fetched), .o_perf_flushed(perf_flushed)
`endif
   );

   fetch_stage_pipelined #(.RESET_PC(16'hFFFC)) dut_wrap (
      .clk(clk), .reset(rst_w), .i_stall(1'b0), .i_taken(1'b0), .i_bt(16'h0000),
      .o_pc_addr(w_addr), .o_pc_rd(w_rd), .i_pc_rddata(w_rddata),
      .o_if_valid(w_valid), .o_if_pc(w_pc), .o_if_npc(w_npc), .o_if_instr(w_instr)
`ifdef FETCH_PERF_EN
      , .o_perf_fetched(w_perf_fetched), .o_perf_flushed(w_perf_flushed)
`endif
   );

   // Instruction memory models: mem[a] = a ^ 16'hA5A5, one-cycle read latency.
   always @(posedge clk) if (pc_rd) rddata   <= pc_addr ^ 16'hA5A5;
   always @(posedge clk) if (w_rd)  w_rddata <= w_addr ^ 16'hA5A5;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        stall;
      logic        taken;
      logic [15:0] bt;
      logic        exp_rd;
      logic [15:0] exp_addr;
      logic        exp_v;
      logic [15:0] exp_pc;
   } vec_t;

   localparam int NV = 25;
   vec_t vecs [NV];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      //           stall taken bt       rd    addr      v     pc (after edge)
      vecs[0]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000};
      vecs[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b1, 16'h0000};
      vecs[2]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0004, 1'b1, 16'h0002};
      vecs[3]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0006, 1'b1, 16'h0004};
      vecs[4]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0008, 1'b1, 16'h0006};
      vecs[5]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h000A, 1'b1, 16'h0006};
      vecs[6]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h000A, 1'b1, 16'h0006};
      vecs[7]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h000A, 1'b1, 16'h0006};
      vecs[8]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h000A, 1'b1, 16'h0008};
      vecs[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h000C, 1'b1, 16'h000A};
      vecs[10] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h000E, 1'b1, 16'h000C};
      vecs[11] = '{1'b0, 1'b1, 16'h0101, 1'b1, 16'h0010, 1'b0, 16'h0000};
      vecs[12] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0100, 1'b0, 16'h0000};
      vecs[13] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0102, 1'b1, 16'h0100};
      vecs[14] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0104, 1'b1, 16'h0102};
      vecs[15] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0106, 1'b1, 16'h0102};
      vecs[16] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0106, 1'b1, 16'h0102};
      vecs[17] = '{1'b1, 1'b1, 16'h0203, 1'b1, 16'h0106, 1'b0, 16'h0000};
      vecs[18] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0202, 1'b0, 16'h0000};
      vecs[19] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0204, 1'b1, 16'h0202};
      vecs[20] = '{1'b1, 1'b1, 16'h0041, 1'b1, 16'h0206, 1'b0, 16'h0000};
      vecs[21] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0040, 1'b0, 16'h0000};
      vecs[22] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0040, 1'b0, 16'h0000};
      vecs[23] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0042, 1'b1, 16'h0040};
      vecs[24] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0044, 1'b1, 16'h0042};

      reset = 1'b1; rst_w = 1'b1; stall = 1'b0; taken = 1'b0; bt = 16'h0000;
      repeat (2) @(negedge clk);

      // Reset state.
      check("rst valid", 32'(if_valid), 32'd0);
      check("rst pc",    32'(if_pc),    32'd0);
      check("rst npc",   32'(if_npc),   32'd0);
      check("rst instr", 32'(if_instr), 32'd0);
      check("rst rd",    32'(pc_rd),    32'd0);
      check("rst addr",  32'(pc_addr),  32'd0);
      check("rst wrap addr", 32'(w_addr), 32'h0000FFFC);
`ifdef FETCH_PERF_EN
      check("rst perf_fetched", perf_fetched, 32'd0);
      check("rst perf_flushed", perf_flushed, 32'd0);
`endif

      // Vector table: inputs at negedge, combinational outputs checked before
      // the edge, IF/ID checked just after it.
      reset = 1'b0;
      for (int k = 0; k < NV; k++) begin
         stall = vecs[k].stall;
         taken = vecs[k].taken;
         bt    = vecs[k].bt;
         #1;
         check($sformatf("v%0d rd", k),   32'(pc_rd),   32'(vecs[k].exp_rd));
         check($sformatf("v%0d addr", k), 32'(pc_addr), 32'(vecs[k].exp_addr));
         @(posedge clk); #1;
         check($sformatf("v%0d valid", k), 32'(if_valid), 32'(vecs[k].exp_v));
         if (vecs[k].exp_v) begin
            check($sformatf("v%0d pc", k),    32'(if_pc),    32'(vecs[k].exp_pc));
            check($sformatf("v%0d npc", k),   32'(if_npc),   32'(vecs[k].exp_pc + 16'd2));
            check($sformatf("v%0d instr", k), 32'(if_instr), 32'(vecs[k].exp_pc ^ 16'hA5A5));
         end
         @(negedge clk);
      end
      stall = 1'b0; taken = 1'b0;

`ifdef FETCH_PERF_EN
      // Live loads: vectors 1-4, 8-10, 13, 14, 19, 23, 24. Kills: 2+2+2.
      check("perf_fetched", perf_fetched, 32'd12);
      check("perf_flushed", perf_flushed, 32'd6);
`endif

      // Reset pulsed mid-stall: skid fills, then reset drops everything at once.
      stall = 1'b1;
      @(posedge clk); @(negedge clk);
      @(posedge clk); @(negedge clk);
      check("stall hold valid", 32'(if_valid), 32'd1);
      reset = 1'b1;
      #1;
      check("midrst valid", 32'(if_valid), 32'd0);
      check("midrst rd",    32'(pc_rd),    32'd0);
      check("midrst addr",  32'(pc_addr),  32'd0);
`ifdef FETCH_PERF_EN
      check("midrst perf_fetched", perf_fetched, 32'd0);
`endif
      @(posedge clk); @(negedge clk);
      reset = 1'b0; stall = 1'b0;
      @(posedge clk); #1;
      check("restart e1 valid", 32'(if_valid), 32'd0);
      @(posedge clk); #1;
      check("restart e2 valid", 32'(if_valid), 32'd1);
      check("restart e2 pc",    32'(if_pc),    32'd0);
      check("restart e2 instr", 32'(if_instr), 32'h0000A5A5);
      @(posedge clk); #1;
      check("restart e3 pc",    32'(if_pc),    32'd2);

      // PC wrap on the RESET_PC=FFFC instance.
      @(negedge clk);
      rst_w = 1'b0;
      @(posedge clk); #1;
      check("wrap e1 valid", 32'(w_valid), 32'd0);
      @(posedge clk); #1;
      check("wrap e2 valid", 32'(w_valid), 32'd1);
      check("wrap e2 pc",    32'(w_pc),    32'h0000FFFC);
      check("wrap e2 npc",   32'(w_npc),   32'h0000FFFE);
      @(posedge clk); #1;
      check("wrap e3 pc",    32'(w_pc),    32'h0000FFFE);
      check("wrap e3 npc",   32'(w_npc),   32'h00000000);
      check("wrap e3 instr", 32'(w_instr), 32'(16'hFFFE ^ 16'hA5A5));
      @(posedge clk); #1;
      check("wrap e4 pc",    32'(w_pc),    32'h00000000);
      check("wrap e4 npc",   32'(w_npc),   32'h00000002);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
